// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the RISC-V CPU.
//
// It owns the fetch PC and drives the word address into the combinational
// instruction memory. Each word that comes back is stored with its PC in a
// small FIFO. The FIFO feeds decode through a valid/ready handshake. A redirect
// from execute flushes the FIFO and restarts fetch at the target.
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN - when this is defined, a redirect to a target
//   that is not word aligned sets a sticky misalign_fault and halts fetch.
//   The fault clears on reset or on the next aligned redirect. When it is not
//   defined, the low two bits of the target are dropped and misalign_fault
//   stays 0.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-high reset
//   instr_addr     out  current fetch PC, sent to instruction memory
//   instr          in   instruction word for instr_addr (same cycle)
//   redirect_valid in   taken branch/jump; load redirect_pc and flush
//   redirect_pc    in   redirect target
//   out_valid      out  FIFO head valid toward decode (registered state only)
//   out_ready      in   decode accepts the head entry
//   out_instr      out  head instruction
//   out_pc         out  PC of the head instruction
//   misalign_fault out  sticky misaligned-redirect flag
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  misalign_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  fault;
    logic                  fault_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  pop;
    logic                  push;

    logic [DATA_WIDTH-1:0] slot_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] slot_pc    [FIFO_DEPTH];

    // out_valid comes from the registered count only. This keeps ready and
    // redirect off the combinational path to decode.
    assign out_valid      = (count != '0);
    assign pop            = out_valid & out_ready;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign push           = (state == RUN) & ~redirect_valid &
                            ((count < CNT_W'(FIFO_DEPTH)) | pop);
    assign instr_addr     = fetch_pc;
    assign out_instr      = slot_instr[head];
    assign out_pc         = slot_pc[head];
    assign misalign_fault = fault;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
`else
    // The low bits are ignored in this build. This vector marks them as used on purpose.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
`endif

    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        fault_next = fault;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misaligned) begin
                state_next = HALT;
                fault_next = 1'b1;
            end else begin
                state_next = RUN;
                fault_next = 1'b0;
            end
`else
            state_next = RUN;
            fault_next = 1'b0;
`endif
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // That way every register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            fault <= fault_next;
        end
    end

    // PC, occupancy and pointers. A redirect beats everything else. A pop in
    // the same cycle still counts as consumed by decode, but the flush empties the FIFO anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                tail     <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
        end
    end

    // NOTE: the slot storage is reset on purpose. After reset the head
    // outputs must read as zero, and the FIFO is only a few flops deep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_instr[i] <= '0;
                slot_pc[i]    <= '0;
            end
        end else if (push) begin
            slot_instr[tail] <= instr;
            slot_pc[tail]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The instruction memory model returns 0x1000 + word index. Expected head PCs
// go into a scoreboard queue when the stimulus is set up. On every accepted
// handshake the head is popped and its PC and instruction are compared.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_fault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_addr    (instr_addr),
        .instr         (instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .misalign_fault(misalign_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000 + (addr >> 2);
    endfunction

    assign instr = mem_word(instr_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: on the falling edge, score any handshake that the next rising
    // edge will accept. Then return 1 time unit after that rising edge.
    task automatic cycle();
        logic [31:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL unexpected_out observed_pc=%h expected=none", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_out_pc", out_pc, e);
                check("sb_out_instr", out_instr, mem_word(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pcs(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Reset state
        check("rst_instr_addr", instr_addr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_fault", 32'(misalign_fault), 32'h0);

        // Backpressure from reset release: the FIFO fills and the PC freezes at 0x8
        rst = 1'b0;
        cycle();
        check("bp1_count", 32'(dut.count), 32'd1);
        check("bp1_instr_addr", instr_addr, 32'h4);
        for (int i = 0; i < 4; i++) cycle();
        check("bp_count_sat", 32'(dut.count), 32'd2);
        check("bp_instr_addr", instr_addr, 32'h8);
        check("bp_out_valid", 32'(out_valid), 32'h1);
        check("bp_head_pc", out_pc, 32'h0);

        // Release: PCs arrive in order, one per cycle
        out_ready = 1'b1;
        expect_pcs(32'h0, 6);
        for (int i = 0; i < 6; i++) cycle();
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);

        // Redirect to 0x40 while the FIFO is full; stale entries must never be presented
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        check("redir_out_valid", 32'(out_valid), 32'h0);
        check("redir_instr_addr", instr_addr, 32'h40);
        check("redir_count", 32'(dut.count), 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        expect_pcs(32'h40, 3);
        cycle();
        check("redir_n1_valid", 32'(out_valid), 32'h1);
        check("redir_n1_pc", out_pc, 32'h40);
        for (int i = 0; i < 3; i++) cycle();
        check("redir_q_empty", 32'(exp_q.size()), 32'd0);

        // Redirect with a pop in the same cycle, then wrap past 0xFFFF_FFFC
        exp_q.push_back(32'h4C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cycle();
        check("wrap_out_valid", 32'(out_valid), 32'h0);
        check("wrap_instr_addr", instr_addr, 32'hFFFF_FFF8);
        redirect_valid = 1'b0;
        expect_pcs(32'hFFFF_FFF8, 4);
        for (int i = 0; i < 5; i++) cycle();
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // Misaligned redirect to 0x42 (head 0x8 is consumed in that cycle)
        exp_q.push_back(32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        cycle();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_fault", 32'(misalign_fault), 32'h1);
        check("mis_out_valid", 32'(out_valid), 32'h0);
        check("mis_instr_addr", instr_addr, 32'h42);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("halt_out_valid", 32'(out_valid), 32'h0);
        end
        check("halt_fault_sticky", 32'(misalign_fault), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cycle();
        redirect_valid = 1'b0;
        check("unhalt_fault", 32'(misalign_fault), 32'h0);
        check("unhalt_instr_addr", instr_addr, 32'h80);
        exp_q.push_back(32'h80);
        cycle();
        check("unhalt_valid", 32'(out_valid), 32'h1);
        check("unhalt_pc", out_pc, 32'h80);
        cycle();
`else
        check("mis_instr_addr", instr_addr, 32'h40);
        check("mis_fault", 32'(misalign_fault), 32'h0);
        check("mis_out_valid", 32'(out_valid), 32'h0);
        expect_pcs(32'h40, 2);
        cycle();
        check("mis_n1_valid", 32'(out_valid), 32'h1);
        check("mis_n1_pc", out_pc, 32'h40);
        check("mis_n1_fault", 32'(misalign_fault), 32'h0);
        for (int i = 0; i < 2; i++) cycle();
`endif
        check("mis_q_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset between edges, with a full FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
        check("pre_arst_count", 32'(dut.count), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_count", 32'(dut.count), 32'd0);
        check("arst_instr_addr", instr_addr, 32'h0);
        check("arst_out_pc", out_pc, 32'h0);
        check("arst_fault", 32'(misalign_fault), 32'h0);
        #1 rst = 1'b0;

        // Reset release with decode ready: 0x0, 0x4, ... on consecutive cycles
        out_ready = 1'b1;
        expect_pcs(32'h0, 4);
        cycle();
        check("first_valid", 32'(out_valid), 32'h1);
        check("first_pc", out_pc, 32'h0);
        for (int i = 0; i < 4; i++) cycle();
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
